// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built from one full-adder cell
// and a registered carry. Operands are captured on an accepted start and
// processed LSB-first, one bit per clock. The result is published with a
// one-cycle done pulse.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   When it is defined, sub=1 computes a - b as a + ~b + 1, and carryin is
//   ignored for that operation. When it is undefined, sub is ignored.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start             request (accepted in IDLE or DONE, ignored in RUN)
//   a, b, carryin     operands and initial carry, captured on accept
//   sub               subtract request (see macro above)
//   busy              high while bits are processed
//   done              one-cycle result-valid pulse
//   sum, carryout     registered result; held until the next completion
//   overflow          signed overflow (carry into MSB ^ carry out of MSB)
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  // Full-adder cell shared by every bit position.
  logic s_bit, c_nxt, last_bit, c_msb_in;
  assign s_bit    = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
  assign c_nxt    = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  // The carry into the MSB is the carry held while the MSB is processed.
  // Because completion happens on that same edge, no separate flop is needed.
  assign c_msb_in = c_q;

`ifndef SERIAL_ADDER_SUB_EN
  logic sub_unused;
  assign sub_unused = sub;
`endif

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        c_d    = c_nxt;
        cnt_d  = cnt_q + CW'(1);
        // Sum bits enter from the MSB side. After WIDTH shifts, bit 0 has
        // reached position 0.
        work_d = {s_bit, work_q[WIDTH-1:1]};
        if (last_bit) begin
          sum_d   = {s_bit, work_q[WIDTH-1:1]};
          cout_d  = c_nxt;
          ovf_d   = c_msb_in ^ c_nxt;
          state_d = S_DONE;
        end
      end
      default: begin // S_IDLE, S_DONE
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          c_d     = carryin;
`ifdef SERIAL_ADDER_SUB_EN
          if (sub) begin
            b_sh_d = ~b;
            c_d    = 1'b1;
          end
`endif
          cnt_d   = '0;
          work_d  = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign sum      = sum_q;
  assign carryout = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         carryin = 1'b0, sub = 1'b0;
  logic         busy, done, carryout, overflow;
  logic [W-1:0] sum;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .carryin(carryin), .sub(sub), .busy(busy), .done(done),
    .sum(sum), .carryout(carryout), .overflow(overflow)
  );

  // Reference: {overflow, carryout, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, mb,
                                         input logic mc, ms);
    logic [W-1:0] bb;
    logic         c;
    logic [W:0]   full;
    logic         ov;
    bb = mb;
    c  = mc;
`ifdef SERIAL_ADDER_SUB_EN
    if (ms) begin bb = ~mb; c = 1'b1; end
`else
    if (ms) c = mc;
`endif
    full = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, c};
    ov   = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
    return {ov, full[W], full[W-1:0]};
  endfunction

  // Issue one operation from a negedge. Returns at the negedge on which done
  // is first seen. lat counts the edges from acceptance to that point (W is
  // expected, -1 means timeout). bcnt counts the cycles with busy high.
  task automatic run_op(input logic [W-1:0] ta, tb_, input logic tc, ts,
                        output int lat, output logic [W-1:0] rs,
                        output logic rc, ro, output int bcnt);
    a = ta; b = tb_; carryin = tc; sub = ts; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); carryin = 1'($urandom); sub = 1'($urandom);
    lat = 0; bcnt = 0;
    while (!done && lat < 3*W) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
    rs = sum; rc = carryout; ro = overflow;
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if ({busy, done, sum, carryout, overflow} !== '0) begin
      n_err++;
      $display("FAIL reset_state got busy=%b done=%b sum=%h co=%b ov=%b exp all 0",
               busy, done, sum, carryout, overflow);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle got busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va[5]  = '{8'h00, 8'hFF, 8'h7F, 8'h80, 8'h0F};
    logic [W-1:0] vb[5]  = '{8'h00, 8'h01, 8'h01, 8'h80, 8'hF0};
    logic         vc[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] es[5]  = '{8'h00, 8'h00, 8'h80, 8'h00, 8'h00};
    logic         eco[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic         eov[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int lat, bcnt;
    logic [W-1:0] rs;
    logic rc, ro;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], vc[i], 1'b0, lat, rs, rc, ro, bcnt);
      n_vec++;
      if (lat !== W || bcnt !== W) begin
        n_err++;
        $display("FAIL dir%0d_latency got lat=%0d busy=%0d exp %0d %0d", i, lat, bcnt, W, W);
      end
      n_vec++;
      if ({rs, rc, ro} !== {es[i], eco[i], eov[i]}) begin
        n_err++;
        $display("FAIL dir%0d_result got sum=%h co=%b ov=%b exp sum=%h co=%b ov=%b",
                 i, rs, rc, ro, es[i], eco[i], eov[i]);
      end
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL dir%0d_done_pulse got done=%b busy=%b exp 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_random();
    int lat, bcnt;
    logic [W-1:0] ra, rb, rs;
    logic rcin, rsub, rc, ro;
    logic [W+1:0] e;
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      rcin = 1'($urandom); rsub = 1'($urandom);
      e = model(ra, rb, rcin, rsub);
      run_op(ra, rb, rcin, rsub, lat, rs, rc, ro, bcnt);
      n_vec++;
      if (lat !== W || {ro, rc, rs} !== e) begin
        n_err++;
        $display("FAIL rand%0d a=%h b=%h ci=%b sub=%b got lat=%0d ov=%b co=%b sum=%h exp lat=%0d ov=%b co=%b sum=%h",
                 i, ra, rb, rcin, rsub, lat, ro, rc, rs, W, e[W+1], e[W], e[W-1:0]);
      end
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end
  endtask

  task automatic test_hold_during_run();
    int lat, bcnt, k;
    logic [W-1:0] rs;
    logic rc, ro;
    logic [W+1:0] e;
    run_op(8'h12, 8'h34, 1'b0, 1'b0, lat, rs, rc, ro, bcnt);
    @(negedge clk);
    e = model(8'hA5, 8'h3C, 1'b1, 1'b0);
    a = 8'hA5; b = 8'h3C; carryin = 1'b1; sub = 1'b0; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 3*W) begin
      n_vec++;
      if (sum !== 8'h46 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL hold_cyc%0d got sum=%h busy=%b exp sum=46 busy=1", k, sum, busy);
      end
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (k !== W || {overflow, carryout, sum} !== e) begin
      n_err++;
      $display("FAIL hold_result got lat=%0d ov=%b co=%b sum=%h exp lat=%0d ov=%b co=%b sum=%h",
               k, overflow, carryout, sum, W, e[W+1], e[W], e[W-1:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start_in_run();
    int k;
    a = 8'h0F; b = 8'h01; carryin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); @(negedge clk);                    // accepted at E
    start = 1'b0;
    @(negedge clk);
    a = 8'hAA; b = 8'h55; carryin = 1'b1; start = 1'b1; // seen at E+2
    @(negedge clk);
    start = 1'b0;
    k = 2;
    while (!done && k < 3*W) begin @(negedge clk); k++; end
    n_vec++;
    if (k !== W || sum !== 8'h10 || carryout !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ignore_start got lat=%0d sum=%h co=%b ov=%b exp lat=%0d sum=10 co=0 ov=0",
               k, sum, carryout, overflow, W);
    end
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL ignore_no_restart got busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 5;
    logic [W-1:0] qa[N], qb[N];
    logic         qc[N];
    logic [W+1:0] e;
    int idx, cyc, last;
    for (int i = 0; i < N; i++) begin
      qa[i] = W'($urandom); qb[i] = W'($urandom); qc[i] = 1'($urandom);
    end
    a = qa[0]; b = qb[0]; carryin = qc[0]; sub = 1'b0; start = 1'b1;
    idx = 0; cyc = 0; last = 0;
    while (idx < N && cyc < 20*W) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        e = model(qa[idx], qb[idx], qc[idx], 1'b0);
        n_vec++;
        if ({overflow, carryout, sum} !== e) begin
          n_err++;
          $display("FAIL b2b%0d got ov=%b co=%b sum=%h exp ov=%b co=%b sum=%h",
                   idx, overflow, carryout, sum, e[W+1], e[W], e[W-1:0]);
        end
        if (idx > 0) begin
          n_vec++;
          if (cyc - last !== W + 1) begin
            n_err++;
            $display("FAIL b2b%0d_period got %0d exp %0d", idx, cyc - last, W + 1);
          end
        end
        last = cyc;
        idx++;
        if (idx < N) begin
          a = qa[idx]; b = qb[idx]; carryin = qc[idx];
        end else start = 1'b0;
      end
    end
    start = 1'b0;
    n_vec++;
    if (idx !== N) begin
      n_err++;
      $display("FAIL b2b_timeout got %0d results exp %0d", idx, N);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    int lat, bcnt, seen;
    logic [W-1:0] rs;
    logic rc, ro;
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, lat, rs, rc, ro, bcnt); // leaves non-zero outputs
    @(negedge clk);
    a = 8'h33; b = 8'h44; carryin = 1'b0; start = 1'b1;
    @(posedge clk);                                          // E
    #1 start = 1'b0;
    repeat (4) @(posedge clk);                               // E+4
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, sum, carryout, overflow} !== '0) begin
      n_err++;
      $display("FAIL midreset_async got busy=%b done=%b sum=%h co=%b ov=%b exp all 0",
               busy, done, sum, carryout, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    n_vec++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL midreset_discard got %0d active cycles exp 0", seen);
    end
    run_op(8'h21, 8'h43, 1'b1, 1'b0, lat, rs, rc, ro, bcnt);
    n_vec++;
    if (lat !== W || {rs, rc, ro} !== {8'h65, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL midreset_after got lat=%0d sum=%h co=%b ov=%b exp lat=%0d sum=65 co=0 ov=0",
               lat, rs, rc, ro, W);
    end
    @(negedge clk);
  endtask

  task automatic test_sub();
    int lat, bcnt;
    logic [W-1:0] rs;
    logic rc, ro;
`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h05, 8'h07, 1'b0, 1'b1, lat, rs, rc, ro, bcnt);
    n_vec++;
    if (lat !== W || {rs, rc, ro} !== {8'hFE, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL sub_5m7 got lat=%0d sum=%h co=%b ov=%b exp sum=fe co=0 ov=0", lat, rs, rc, ro);
    end
    @(negedge clk);
    run_op(8'h80, 8'h01, 1'b0, 1'b1, lat, rs, rc, ro, bcnt);
    n_vec++;
    if (lat !== W || {rs, rc, ro} !== {8'h7F, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL sub_80m1 got lat=%0d sum=%h co=%b ov=%b exp sum=7f co=1 ov=1", lat, rs, rc, ro);
    end
`else
    run_op(8'h05, 8'h07, 1'b0, 1'b1, lat, rs, rc, ro, bcnt);
    n_vec++;
    if (lat !== W || {rs, rc, ro} !== {8'h0C, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL sub_ignored got lat=%0d sum=%h co=%b ov=%b exp sum=0c co=0 ov=0", lat, rs, rc, ro);
    end
`endif
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold_during_run();
    test_ignore_start_in_run();
    test_back_to_back();
    test_reset_midop();
    test_sub();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
